mont_domain_conv: RTL and testbench



---
 rtl/mont_domain_conv_if.sv | 30 +++
 rtl/mont_domain_conv.sv | 190 +++++++++++++++++++
 tb/tb_mont_domain_conv.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_domain_conv_if.sv
// -----------------------------------------------------------------------------
// mont_domain_conv_if
// Coefficient stream bundle for the Montgomery domain converter.
//   Input side : in_valid, in_ready, in_data (signed a), in_mode (0 to_mont,
//                1 from_mont)
//   Output side: out_valid, out_ready, out_data (signed result), out_idx
//                (coefficient index within the polynomial), out_last
// master = producer/consumer environment, slave = the converter.
// -----------------------------------------------------------------------------
interface mont_domain_conv_if;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               in_mode;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic [7:0]         out_idx;
    logic               out_last;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/mont_domain_conv.sv
// -----------------------------------------------------------------------------
// mont_domain_conv
// Pipelined converter between the normal and Montgomery domains for Kyber
// coefficients (q = 3329, R = 2^16).
//   mode 0 (to_mont)  : out = montgomery_reduce(a * 1353)  = a*R     mod q
//   mode 1 (from_mont): out = montgomery_reduce(sext32(a)) = a*R^-1  mod q
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; flushes every in-flight beat
//   bus   - slave side of mont_domain_conv_if (valid/ready in and out,
//           signed data, mode tag, coefficient index and last flag)
// Parameters:
//   N_COEF    - coefficients per polynomial (out_last on index N_COEF-1)
//   NORMALIZE - 1: results in [0,q); 0: results in (-q,q)
// A beat accepted at edge k appears on the output after edge k+3. Every stage
// holds while the output register is stalled by out_ready low.
// -----------------------------------------------------------------------------
module mont_domain_conv #(
    parameter int N_COEF    = 256,
    parameter bit NORMALIZE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    mont_domain_conv_if.slave bus
);
    localparam logic signed [31:0] Q_32     = 32'sd3329;
    localparam logic signed [15:0] Q_16     = 16'sd3329;
    localparam logic signed [31:0] R2_MOD_Q = 32'sd1353;
    localparam logic signed [15:0] Q_INV    = -16'sd3327;
    localparam logic [7:0]         LAST_IDX = 8'(N_COEF - 1);

    // stage registers
    logic               ready_en_r;
    logic               s1_valid_r;
    logic               s1_mode_r;
    logic signed [15:0] s1_a_r;
    logic               s2_valid_r;
    logic signed [31:0] s2_p_r;
    logic               s3_valid_r;
    logic signed [31:0] s3_p_r;
    logic signed [15:0] s3_t_r;
    logic               out_valid_r;
    logic signed [15:0] out_data_r;
    logic [7:0]         out_idx_r;
    logic               out_last_r;

    // combinational
    logic               stall_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               xfer_s;
    logic signed [31:0] p_s;
    logic signed [15:0] t_s;
    logic signed [31:0] diff_s;
    logic signed [15:0] r_s;
    logic signed [15:0] res_s;
    logic [15:0]        diff_low_unused_s;
    logic [7:0]         idx_next_s;

    // Handshake: the whole pipe freezes while the output is held.
    // ready_en_r keeps in_ready low during reset and releases it one cycle later.
    always_comb begin
        stall_s    = out_valid_r & ~bus.out_ready;
        in_ready_s = ready_en_r & ~stall_s;
        accept_s   = bus.in_valid & in_ready_s;
        xfer_s     = out_valid_r & bus.out_ready;
    end

    // S1 arithmetic: widen the coefficient, scaling by R^2 mod q for to_mont.
    always_comb begin
        if (s1_mode_r) begin
            p_s = 32'(s1_a_r);
        end else begin
            p_s = 32'(s1_a_r) * R2_MOD_Q;
        end
    end

    // S2 arithmetic: t = low16(p) * q^-1, only the low 16 bits matter.
    always_comb begin
        t_s = s2_p_r[15:0] * Q_INV;
    end

    // S3 arithmetic: p - t*q has zero low half by construction, so the
    // arithmetic shift by 16 is just the upper half.
    always_comb begin
        diff_s            = s3_p_r - 32'(s3_t_r) * Q_32;
        r_s               = diff_s[31:16];
        diff_low_unused_s = diff_s[15:0];
        if ((NORMALIZE == 1'b1) && (r_s < 16'sd0)) begin
            res_s = r_s + Q_16;
        end else begin
            res_s = r_s;
        end
    end

    // Next coefficient index: advances on each output transfer, wraps after last.
    always_comb begin
        if (xfer_s) begin
            if (out_idx_r == LAST_IDX) begin
                idx_next_s = 8'd0;
            end else begin
                idx_next_s = out_idx_r + 8'd1;
            end
        end else begin
            idx_next_s = out_idx_r;
        end
    end

    // Input-ready enable, low throughout reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // Stage 1: capture the accepted beat and its mode tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= 1'b0;
            s1_a_r     <= 16'sd0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_a_r    <= bus.in_data;
                s1_mode_r <= bus.in_mode;
            end
        end
    end

    // Stage 2: register the 32-bit product p.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_r <= 1'b0;
            s2_p_r     <= 32'sd0;
        end else if (!stall_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_p_r <= p_s;
            end
        end
    end

    // Stage 3: register the reduction factor t alongside p.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid_r <= 1'b0;
            s3_p_r     <= 32'sd0;
            s3_t_r     <= 16'sd0;
        end else if (!stall_s) begin
            s3_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                s3_p_r <= s2_p_r;
                s3_t_r <= t_s;
            end
        end
    end

    // Output register: result, valid and last flag; held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= 16'sd0;
            out_last_r  <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= s3_valid_r;
            out_last_r  <= s3_valid_r & (idx_next_s == LAST_IDX);
            if (s3_valid_r) begin
                out_data_r <= res_s;
            end
        end
    end

    // Coefficient index counter; a transfer implies no stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_idx_r <= 8'd0;
        end else begin
            out_idx_r <= idx_next_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
endmodule

// File: tb/tb_mont_domain_conv.sv
// -----------------------------------------------------------------------------
// tb_mont_domain_conv
// Two converters (NORMALIZE=0 and NORMALIZE=1) driven by the same stream.
// Expected results come from plain modular arithmetic: a*R mod q and
// a*R^-1 mod q, with R^-1 found by search. A negedge monitor scoreboards
// every output transfer; hand sequences cover latency, backpressure,
// the polynomial boundary and reset with beats in flight.
// -----------------------------------------------------------------------------
module tb_mont_domain_conv;
    localparam int     N_COEF = 256;
    localparam int     Q      = 3329;
    localparam longint R      = 65536;

    logic               clk         = 1'b0;
    logic               reset       = 1'b1;
    logic               in_valid_d  = 1'b0;
    logic signed [15:0] in_data_d   = 16'sd0;
    logic               in_mode_d   = 1'b0;
    logic               out_ready_d = 1'b1;
    int                 drv_exp     = 0;

    int checks     = 0;
    int failures   = 0;
    int sb[$];
    int rt_cap[$];
    bit capture_en = 1'b0;
    bit rand_ready = 1'b0;
    int idx_model  = 0;
    int lasts_seen = 0;
    int xfers      = 0;
    int r_inv      = 0;

    typedef struct {
        int a;
        bit mode;
        int exp0;
        int exp1;
    } vec_t;
    vec_t vecs[7];

    mont_domain_conv_if if0 ();
    mont_domain_conv_if if1 ();

    assign if0.in_valid  = in_valid_d;
    assign if0.in_data   = in_data_d;
    assign if0.in_mode   = in_mode_d;
    assign if0.out_ready = out_ready_d;
    assign if1.in_valid  = in_valid_d;
    assign if1.in_data   = in_data_d;
    assign if1.in_mode   = in_mode_d;
    assign if1.out_ready = out_ready_d;

    mont_domain_conv #(.N_COEF(N_COEF), .NORMALIZE(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    mont_domain_conv #(.N_COEF(N_COEF), .NORMALIZE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    always #5 clk = ~clk;

    function automatic int modq(input longint x);
        longint m;
        m = x % Q;
        if (m < 0) m = m + Q;
        return int'(m);
    endfunction

    function automatic int to_mont_ref(input int a);
        return modq(longint'(a) * R);
    endfunction

    function automatic int from_mont_ref(input int a);
        return modq(longint'(a) * longint'(r_inv));
    endfunction

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic signed [15:0] a, input logic mode, input int exp);
        logic acc;
        int   waited;
        waited     = 0;
        in_valid_d = 1'b1;
        in_data_d  = a;
        in_mode_d  = mode;
        drv_exp    = exp;
        forever begin
            @(negedge clk);
            acc = if0.in_ready;
            @(posedge clk);
            #1;
            if (acc === 1'b1) break;
            waited++;
            if (waited > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        in_valid_d = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || if0.out_valid !== 1'b0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, sb.size(), 0);
    endtask

    // Random backpressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready_d = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    initial begin
        bit                 held;
        logic signed [15:0] h_d0, h_d1;
        logic [7:0]         h_idx;
        logic               h_last;
        int                 e;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                idx_model = 0;
                held      = 1'b0;
            end else begin
                if (held) begin
                    check("hold_data0", if0.out_data, h_d0);
                    check("hold_data1", if1.out_data, h_d1);
                    check("hold_idx", if0.out_idx, h_idx);
                    check("hold_last", if0.out_last, h_last);
                end
                if (if0.out_valid === 1'b1 && out_ready_d === 1'b1) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        check("stale_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_valid_n1", if1.out_valid, 1);
                        check("data_norm1", if1.out_data, e);
                        check("data_norm0_cong", modq(longint'(if0.out_data)), e);
                        check("data_norm0_range",
                              (if0.out_data > -16'sd3329 && if0.out_data < 16'sd3329) ? 1 : 0, 1);
                        check("out_idx", if0.out_idx, idx_model);
                        check("out_last", if0.out_last, (idx_model == N_COEF - 1) ? 1 : 0);
                        if (if0.out_last === 1'b1) lasts_seen++;
                        idx_model = (idx_model + 1) % N_COEF;
                        if (capture_en) rt_cap.push_back(int'(if0.out_data));
                    end
                end
                held   = (if0.out_valid === 1'b1) && (out_ready_d === 1'b0);
                h_d0   = if0.out_data;
                h_d1   = if1.out_data;
                h_idx  = if0.out_idx;
                h_last = if0.out_last;
                if (in_valid_d === 1'b1 && if0.in_ready === 1'b1) sb.push_back(drv_exp);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] a;
        int n_before, last_before, n;

        vecs[0] = '{a: 1,      mode: 1'b0, exp0: -1044, exp1: 2285};
        vecs[1] = '{a: 0,      mode: 1'b0, exp0: 0,     exp1: 0};
        vecs[2] = '{a: 3328,   mode: 1'b0, exp0: 1044,  exp1: 1044};
        vecs[3] = '{a: 1,      mode: 1'b1, exp0: 169,   exp1: 169};
        vecs[4] = '{a: -1,     mode: 1'b1, exp0: -169,  exp1: 3160};
        vecs[5] = '{a: -32768, mode: 1'b0, exp0: 988,   exp1: 988};
        vecs[6] = '{a: -32768, mode: 1'b1, exp0: 1664,  exp1: 1664};

        for (int x = 1; x < Q; x++) begin
            if (modq(R * longint'(x)) == 1) r_inv = x;
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", if0.out_valid, 0);
        check("rst_out_data0", if0.out_data, 0);
        check("rst_out_data1", if1.out_data, 0);
        check("rst_out_idx", if0.out_idx, 0);
        check("rst_out_last", if0.out_last, 0);
        check("rst_in_ready", if0.in_ready, 0);
        reset = 1'b0;
        check("in_ready_deassert_cycle", if0.in_ready, 0);
        idle(1);
        check("in_ready_after_reset", if0.in_ready, 1);

        // ---- table vectors, exact values and exact latency ----
        for (int c = 0; c < 7 + 4; c++) begin
            if (c < 7) begin
                in_valid_d = 1'b1;
                in_data_d  = 16'(vecs[c].a);
                in_mode_d  = vecs[c].mode;
                drv_exp    = vecs[c].exp1;
            end else begin
                in_valid_d = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c == 2) begin
                check("latency_not_early", if0.out_valid, 0);
            end else if (c >= 3 && c - 3 < 7) begin
                check("tbl_valid", if0.out_valid, 1);
                check("tbl_norm0", if0.out_data, vecs[c - 3].exp0);
                check("tbl_norm1", if1.out_data, vecs[c - 3].exp1);
                check("tbl_idx", if0.out_idx, c - 3);
            end
        end
        drain("tbl_drain");

        // ---- backpressure mid-stream ----
        out_ready_d = 1'b1;
        n_before    = xfers;
        fork
            begin
                logic signed [15:0] b;
                for (int i = 0; i < 6; i++) begin
                    b = 16'($urandom);
                    send(b, 1'b0, to_mont_ref(int'(b)));
                end
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (if0.out_valid !== 1'b1 && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_first_valid", if0.out_valid, 1);
                @(posedge clk);
                #1;
                out_ready_d = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_in_ready_low", if0.in_ready, 0);
                    check("bp_out_valid_held", if0.out_valid, 1);
                    @(posedge clk);
                    #1;
                end
                out_ready_d = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_count", xfers - n_before, 6);

        // ---- reset with three beats in flight ----
        for (int i = 0; i < 3; i++) send(16'sd100 + 16'(i), 1'b0, to_mont_ref(100 + i));
        reset = 1'b1;
        idle(1);
        check("rif_out_valid", if0.out_valid, 0);
        check("rif_out_idx", if0.out_idx, 0);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if0.out_valid !== 1'b0) n++;
            @(posedge clk);
            #1;
        end
        check("rif_no_stale", n, 0);

        // ---- polynomial boundary ----
        last_before = lasts_seen;
        for (int i = 0; i < N_COEF + 2; i++) begin
            a = 16'($urandom);
            send(a, 1'b0, to_mont_ref(int'(a)));
        end
        drain("poly_drain");
        check("poly_last_count", lasts_seen - last_before, 1);

        // ---- round trip over [-3328, 3328] with random gaps and backpressure ----
        rand_ready = 1'b1;
        capture_en = 1'b1;
        for (int v = -3328; v <= 3328; v++) begin
            send(16'(v), 1'b0, to_mont_ref(v));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain("rt_a_drain");
        capture_en = 1'b0;
        check("rt_capture_size", rt_cap.size(), 6657);
        for (int i = 0; i < rt_cap.size(); i++) begin
            send(16'(rt_cap[i]), 1'b1, modq(longint'(i - 3328)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        drain("rt_b_drain");

        // ---- random mixed-mode stream ----
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) send(a, 1'b1, from_mont_ref(int'(a)));
            else                           send(a, 1'b0, to_mont_ref(int'(a)));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain("rand_drain");
        rand_ready  = 1'b0;
        out_ready_d = 1'b1;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
